// File: rtl/rl_dmp_ecc_pipe_decoder.sv
// Two-stage extended-Hamming (SECDED) read decoder with address folding,
// error counters, first-error capture and a single-entry scrub write-back port.
module rl_dmp_ecc_pipe_decoder #(
    parameter int               DATA_W   = 32,
    parameter int               ADDR_W   = 17,
    parameter int               ECC_W    = 8,
    parameter int               CNT_W    = 8,
    parameter logic [ECC_W-1:0] INV_MASK = 8'h03
) (
    input  logic              clk,
    input  logic              rst_a,
    input  logic              enable,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ECC_W-1:0]  in_ecc,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ECC_W-1:0]  out_ecc,
    output logic [ECC_W-2:0]  out_syndrome,
    output logic              out_single_err,
    output logic              out_double_err,
    output logic              out_addr_err,
    output logic [CNT_W-1:0]  sb_cnt,
    output logic [CNT_W-1:0]  db_cnt,
    input  logic              err_clr,
    output logic              cap_valid,
    output logic [ADDR_W-1:0] cap_addr,
    output logic [ECC_W-2:0]  cap_syndrome,
    output logic              scrub_req,
    output logic [ADDR_W-1:0] scrub_addr,
    output logic [DATA_W-1:0] scrub_data,
    output logic [ECC_W-1:0]  scrub_ecc,
    input  logic              scrub_ack,
    output logic              scrub_ovf
);

    localparam int HB  = ECC_W - 1;
    localparam int NDA = DATA_W + ADDR_W;

    if (NDA + HB > (1 << HB) - 1) begin : g_code_too_small
        $error("rl_dmp_ecc_pipe_decoder: DATA_W+ADDR_W+ECC_W-1 exceeds 2^(ECC_W-1)-1");
    end

    typedef logic [NDA-1:0][HB-1:0] pos_t;

    // Codeword position of each data (low) and address (high) bit: ascending non-powers of two.
    function automatic pos_t pos_tab();
        pos_t t = '0;
        int   n = 0;
        for (int q = 3; q < (1 << HB); q++) begin
            if ((q & (q - 1)) != 0 && n < NDA) begin
                t[n] = q[HB-1:0];
                n++;
            end
        end
        return t;
    endfunction

    localparam pos_t          POS        = pos_tab();
    localparam logic [HB-1:0] DATA_LAST  = POS[DATA_W-1];
    localparam logic [HB-1:0] ADDR_FIRST = POS[DATA_W];
    localparam logic [HB-1:0] ADDR_LAST  = POS[NDA-1];

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ECC_W-1:0]  ecc;
        logic [ADDR_W-1:0] addr;
        logic [HB-1:0]     syn;
        logic              par;
    } s1_t;

    logic [2:1]        vld_pipe;
    s1_t               s1_q;
    logic [ADDR_W-1:0] s2_addr;
    logic              s2_ld;

    assign out_valid = vld_pipe[2];
    assign s2_ld     = !vld_pipe[2] | out_ready;
    assign in_ready  = !vld_pipe[1] | s2_ld;

    // Stage 1 inputs: syndrome over stored-polarity-corrected check bits
    logic [ECC_W-1:0] e_in;
    logic [NDA-1:0]   da_in;
    logic [HB-1:0]    syn_in;
    logic             par_in;

    always_comb begin
        e_in   = in_ecc ^ INV_MASK;
        da_in  = {in_addr, in_data};
        syn_in = e_in[HB-1:0];
        for (int i = 0; i < NDA; i++)
            if (da_in[i]) syn_in ^= POS[i];
        par_in = ^da_in ^ ^e_in;
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            vld_pipe <= '0;
            s1_q     <= '0;
        end else begin
            if (in_ready) begin
                vld_pipe[1] <= in_valid;
                if (in_valid) s1_q <= '{data: in_data, ecc: in_ecc, addr: in_addr, syn: syn_in, par: par_in};
            end
            if (s2_ld) vld_pipe[2] <= vld_pipe[1];
        end
    end

    // Stage 2 classification and correction
    logic [HB-1:0]     s;
    logic              pow, data_rng, addr_rng;
    logic              c_single, c_double, c_addr;
    logic [DATA_W-1:0] data_fix;
    logic [ECC_W-1:0]  ecc_fix;

    always_comb begin
        s        = s1_q.syn;
        pow      = (s != '0) && ((s & (s - HB'(1))) == '0);
        data_rng = !pow && s >= HB'(3) && s <= DATA_LAST;
        addr_rng = !pow && s >= ADDR_FIRST && s <= ADDR_LAST;
        c_single = 1'b0;
        c_double = 1'b0;
        c_addr   = 1'b0;
        if (enable && s1_q.par) begin
            if (addr_rng)                     c_addr   = 1'b1;
            else if (s == '0 || pow || data_rng) c_single = 1'b1;
            else                              c_double = 1'b1;
        end else if (enable && s != '0) begin
            c_double = 1'b1;
        end
        data_fix = s1_q.data;
        ecc_fix  = s1_q.ecc;
        if (c_single) begin
            for (int i = 0; i < DATA_W; i++)
                if (s == POS[i]) data_fix[i] = ~data_fix[i];
            for (int j = 0; j < HB; j++)
                if (s == HB'(1 << j)) ecc_fix[j] = ~ecc_fix[j];
            if (s == '0) ecc_fix[HB] = ~ecc_fix[HB];
        end
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            out_data       <= '0;
            out_ecc        <= '0;
            out_syndrome   <= '0;
            out_single_err <= 1'b0;
            out_double_err <= 1'b0;
            out_addr_err   <= 1'b0;
            s2_addr        <= '0;
        end else if (s2_ld && vld_pipe[1]) begin
            out_data       <= data_fix;
            out_ecc        <= ecc_fix;
            out_syndrome   <= s;
            out_single_err <= c_single;
            out_double_err <= c_double;
            out_addr_err   <= c_addr;
            s2_addr        <= s1_q.addr;
        end
    end

    logic hs, ev_single, ev_multi;
    assign hs        = vld_pipe[2] & out_ready;
    assign ev_single = hs & out_single_err;
    assign ev_multi  = hs & (out_double_err | out_addr_err);

    // err_clr wins over any same-cycle error event
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            sb_cnt       <= '0;
            db_cnt       <= '0;
            cap_valid    <= 1'b0;
            cap_addr     <= '0;
            cap_syndrome <= '0;
            scrub_ovf    <= 1'b0;
        end else if (err_clr) begin
            sb_cnt       <= '0;
            db_cnt       <= '0;
            cap_valid    <= 1'b0;
            cap_addr     <= '0;
            cap_syndrome <= '0;
            scrub_ovf    <= 1'b0;
        end else begin
            if (ev_single && sb_cnt != '1) sb_cnt <= sb_cnt + CNT_W'(1);
            if (ev_multi && db_cnt != '1)  db_cnt <= db_cnt + CNT_W'(1);
            if ((ev_single || ev_multi) && !cap_valid) begin
                cap_valid    <= 1'b1;
                cap_addr     <= s2_addr;
                cap_syndrome <= out_syndrome;
            end
            if (ev_single && scrub_req) scrub_ovf <= 1'b1;
        end
    end

    // Single-entry scrub slot; a corrected word arriving while it is busy is dropped
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            scrub_req  <= 1'b0;
            scrub_addr <= '0;
            scrub_data <= '0;
            scrub_ecc  <= '0;
        end else if (scrub_req) begin
            if (scrub_ack) scrub_req <= 1'b0;
        end else if (ev_single) begin
            scrub_req  <= 1'b1;
            scrub_addr <= s2_addr;
            scrub_data <= out_data;
            scrub_ecc  <= out_ecc;
        end
    end

endmodule
